// File: rtl/chess_move_pkg.sv
// Shared widths, move-slot field layout and collector state encoding for the board move collector.
// Pure definitions; no timing or backpressure of its own.
package chess_move_pkg;

  localparam int MOVEW  = 19;
  localparam int SLOTW  = 20;
  localparam int NSLOT  = 8;
  localparam int WORDW  = NSLOT * SLOTW;
  localparam int SLOTIW = $clog2(NSLOT);

  // Flag field occupies bits 18..12 of a move, highest bit first.
  localparam int FLG_INVALID  = 18;
  localparam int FLG_PROMOTE  = 17;
  localparam int FLG_PAWN     = 16;
  localparam int FLG_PAWN2    = 15;
  localparam int FLG_EP       = 14;
  localparam int FLG_CASTLE   = 13;
  localparam int FLG_CAPTURE  = 12;
  localparam int FROM_HI      = 11;
  localparam int FROM_LO      = 6;
  localparam int TO_HI        = 5;
  localparam int TO_LO        = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_READ,
    ST_CAPT,
    ST_EMIT,
    ST_DONE
  } state_e;

  // Bit SLOTW*k+19 is reserved and is never returned.
  function automatic logic [MOVEW-1:0] slot_extract(input logic [WORDW-1:0] word,
                                                    input logic [SLOTIW-1:0] k);
    slot_extract = word[SLOTW*k +: MOVEW];
  endfunction

endpackage

// File: rtl/col_rr_scan.sv
// Round-robin column pointer and per-column finished flags; decisions are combinational on ptr.
// State updates every posedge; no backpressure (the FSM decides when to scan or advance).
module col_rr_scan #(
  parameter int NCOL = 8,
  parameter int PTRW = $clog2(NCOL)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            scan_en,
  input  logic            advance,
  input  logic [NCOL-1:0] col_empty,
  input  logic [NCOL-1:0] col_done,
  output logic [PTRW-1:0] ptr,
  output logic            sel_nonempty,
  output logic            all_finished
);

  logic [PTRW-1:0] ptr_q, ptr_d, ptr_inc;
  logic [NCOL-1:0] finished_q, finished_d, fin_next;
  logic            mark;

  always_comb begin
    ptr_inc      = (ptr_q == PTRW'(NCOL - 1)) ? '0 : ptr_q + 1'b1;
    // A finished column is never read again, even if it somehow refills.
    sel_nonempty = ~col_empty[ptr_q] & ~finished_q[ptr_q];
    mark         = scan_en & col_empty[ptr_q] & col_done[ptr_q];
    fin_next     = finished_q;
    if (mark) begin
      fin_next[ptr_q] = 1'b1;
    end
    all_finished = &fin_next;

    ptr_d      = ptr_q;
    finished_d = fin_next;
    if (clear) begin
      ptr_d      = '0;
      finished_d = '0;
    end else if ((scan_en & ~sel_nonempty) | advance) begin
      ptr_d = ptr_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q      <= '0;
      finished_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      finished_q <= finished_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/board_move_collector.sv
// Pops one 160-bit word per column visit, unpacks 8 slots and streams valid 19-bit moves.
// First move 4 cycles after start; move_out/move_valid hold until move_ready.
module board_move_collector
  import chess_move_pkg::*;
#(
  parameter int NCOL = 8,
  parameter int CNTW = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NCOL-1:0]       col_done,
  input  logic [NCOL-1:0]       col_empty,
  input  logic [NCOL*WORDW-1:0] col_data,
  output logic [NCOL-1:0]       col_rden,
  output logic [MOVEW-1:0]      move_out,
  output logic                  move_valid,
  input  logic                  move_ready,
  output logic [CNTW-1:0]       move_count,
  output logic                  busy,
  output logic                  done
);

  localparam int PTRW = $clog2(NCOL);

  state_e            state_q, state_d;
  logic [WORDW-1:0]  word_q, word_d;
  logic [SLOTIW-1:0] slot_q, slot_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic [NCOL-1:0]   rden_q, rden_d;

  logic [PTRW-1:0]   ptr;
  logic              sel_nonempty, all_finished;
  logic              clear, scan_en, advance;
  logic [MOVEW-1:0]  cur_slot;
  logic              slot_ok, slot_done;

  assign scan_en = (state_q == ST_SCAN);

  col_rr_scan #(.NCOL(NCOL), .PTRW(PTRW)) u_scan (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .scan_en      (scan_en),
    .advance      (advance),
    .col_empty    (col_empty),
    .col_done     (col_done),
    .ptr          (ptr),
    .sel_nonempty (sel_nonempty),
    .all_finished (all_finished)
  );

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    slot_d   = slot_q;
    count_d  = count_q;
    rden_d   = '0;
    clear    = 1'b0;
    advance  = 1'b0;
    cur_slot = slot_extract(word_q, slot_q);
    slot_ok  = (state_q == ST_EMIT) & ~cur_slot[FLG_INVALID];
    // Invalid slots retire immediately; valid ones wait for the handshake.
    slot_done = (state_q == ST_EMIT) & (~slot_ok | move_ready);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          clear   = 1'b1;
          count_d = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (all_finished) begin
          state_d = ST_DONE;
        end else if (sel_nonempty) begin
          rden_d[ptr] = 1'b1;
          state_d     = ST_READ;
        end
      end
      ST_READ: begin
        state_d = ST_CAPT;
      end
      ST_CAPT: begin
        word_d  = col_data[WORDW*ptr +: WORDW];
        slot_d  = '0;
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (slot_done) begin
          if (slot_ok && (count_q != '1)) begin
            count_d = count_q + 1'b1;
          end
          if (slot_q == SLOTIW'(NSLOT - 1)) begin
            advance = 1'b1;
            state_d = ST_SCAN;
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      slot_q  <= '0;
      count_q <= '0;
      rden_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      slot_q  <= slot_d;
      count_q <= count_d;
      rden_q  <= rden_d;
    end
  end

  assign col_rden   = rden_q;
  assign move_valid = slot_ok;
  assign move_out   = slot_ok ? cur_slot : '0;
  assign move_count = count_q;
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_board_move_collector.sv
// Bench for board_move_collector: behavioural column FIFOs, round-robin word-level reference model.
module tb_board_move_collector;

  localparam int NCOL  = 8;
  localparam int WORDW = 160;
  localparam int CNTW  = 8;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  start = 1'b0;
  logic [NCOL-1:0]       col_done = '1;
  logic [NCOL-1:0]       col_empty = '1;
  logic [NCOL*WORDW-1:0] col_data = '0;
  logic [NCOL-1:0]       col_rden;
  logic [18:0]           move_out;
  logic                  move_valid;
  logic                  move_ready = 1'b0;
  logic [CNTW-1:0]       move_count;
  logic                  busy, done;

  int errors = 0;
  int checks = 0;
  int ready_mode = 0;
  int onehot_err = 0;
  int rden_cnt [NCOL];

  logic [WORDW-1:0] fifo_q [NCOL][$];
  int               pop_log[$];
  logic [18:0]      got[$];
  logic [18:0]      exp_moves[$];
  int               exp_pops[$];

  always #5 clk = ~clk;

  board_move_collector #(.NCOL(NCOL), .CNTW(CNTW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .col_done   (col_done),
    .col_empty  (col_empty),
    .col_data   (col_data),
    .col_rden   (col_rden),
    .move_out   (move_out),
    .move_valid (move_valid),
    .move_ready (move_ready),
    .move_count (move_count),
    .busy       (busy),
    .done       (done)
  );

  // Non-showahead column FIFOs plus handshake/read-enable monitors.
  always @(posedge clk) begin
    if ($countones(col_rden) > 1) onehot_err++;
    for (int i = 0; i < NCOL; i++) begin
      if (col_rden[i]) rden_cnt[i]++;
      if (col_rden[i] && fifo_q[i].size() > 0) begin
        col_data[WORDW*i +: WORDW] <= fifo_q[i].pop_front();
        pop_log.push_back(i);
      end
      col_empty[i] <= (fifo_q[i].size() == 0);
    end
    if (reset && move_valid && move_ready) got.push_back(move_out);
  end

  always @(negedge clk) begin
    case (ready_mode)
      0:       move_ready = 1'b0;
      1:       move_ready = 1'b1;
      default: move_ready = 1'($urandom_range(0, 1));
    endcase
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_bench();
    for (int c = 0; c < NCOL; c++) begin
      fifo_q[c].delete();
      rden_cnt[c] = 0;
    end
    pop_log.delete();
    got.delete();
  endtask

  function automatic logic [WORDW-1:0] rand_word(input int valid_pct, input bit force0);
    logic [WORDW-1:0] w;
    logic [19:0]      s;
    w = '0;
    for (int k = 0; k < 8; k++) begin
      s     = 20'($urandom);
      s[18] = ($urandom_range(0, 99) >= valid_pct);
      if (force0 && k == 0) s[18] = 1'b0;
      w[20*k +: 20] = s;
    end
    return w;
  endfunction

  // Reference: visit columns 0..NCOL-1 cyclically, one word per non-empty column per visit.
  task automatic compute_expected();
    logic [WORDW-1:0] m [NCOL][$];
    logic [WORDW-1:0] w;
    int left = 0;
    int p = 0;
    exp_moves.delete();
    exp_pops.delete();
    for (int c = 0; c < NCOL; c++) begin
      m[c] = fifo_q[c];
      left += m[c].size();
    end
    while (left > 0) begin
      if (m[p].size() > 0) begin
        w = m[p].pop_front();
        left--;
        exp_pops.push_back(p);
        for (int k = 0; k < 8; k++)
          if (!w[20*k + 18]) exp_moves.push_back(w[20*k +: 19]);
      end
      p = (p + 1) % NCOL;
    end
  endtask

  task automatic run_pass(input int budget, output bit to);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        to = 1'b0;
        break;
      end
      tick(1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(3);
    checks++; if (col_rden !== '0)   begin errors++; $display("FAIL reset_rden: got %h want 0", col_rden); end
    checks++; if (move_valid !== 0)  begin errors++; $display("FAIL reset_valid: got %b want 0", move_valid); end
    checks++; if (move_out !== '0)   begin errors++; $display("FAIL reset_out: got %h want 0", move_out); end
    checks++; if (move_count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", move_count); end
    checks++; if (busy !== 0)        begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 0)        begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    reset = 1'b1;
    tick(1);
  endtask

  task automatic test_single_col();
    logic [WORDW-1:0] w;
    logic [18:0] want [3];
    bit to;
    want[0] = 19'h00C1C; want[1] = 19'h00820; want[2] = 19'h01010;
    clear_bench();
    for (int k = 0; k < 8; k++) w[20*k +: 20] = 20'h40000 | 20'($urandom_range(0, 'h3FFFF));
    w[0   +: 20] = 20'h00C1C;
    w[40  +: 20] = 20'h80820;  // reserved bit set: must not reach move_out
    w[100 +: 20] = 20'h01010;
    fifo_q[3].push_back(w);
    ready_mode = 1;
    tick(2);
    run_pass(200, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL single_done_timeout: done=%b want 1", done); end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL single_nmoves: got %0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== want[i]) begin errors++; $display("FAIL single_move%0d: got %h want %h", i, got[i], want[i]); end
    end
    checks++; if (move_count !== 8'd3) begin errors++; $display("FAIL single_count: got %0d want 3", move_count); end
    checks++; if (rden_cnt[3] != 1) begin errors++; $display("FAIL single_rden3: got %0d pulses want 1", rden_cnt[3]); end
    checks++; if (pop_log.size() != 1) begin errors++; $display("FAIL single_pops: got %0d want 1", pop_log.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    bit to;
    int want_pops [4];
    want_pops[0] = 0; want_pops[1] = 1; want_pops[2] = 0; want_pops[3] = 1;
    clear_bench();
    for (int j = 0; j < 2; j++) begin
      fifo_q[0].push_back(rand_word(60, 0));
      fifo_q[1].push_back(rand_word(60, 0));
    end
    ready_mode = 2;
    tick(2);
    compute_expected();
    run_pass(400, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL rr_done_timeout: done=%b want 1", done); end
    checks++; if (pop_log.size() != 4) begin errors++; $display("FAIL rr_npops: got %0d want 4", pop_log.size()); end
    for (int i = 0; i < 4 && i < pop_log.size(); i++) begin
      checks++;
      if (pop_log[i] != want_pops[i]) begin errors++; $display("FAIL rr_pop%0d: got col %0d want col %0d", i, pop_log[i], want_pops[i]); end
    end
    checks++; if (got.size() != exp_moves.size()) begin errors++; $display("FAIL rr_nmoves: got %0d want %0d", got.size(), exp_moves.size()); end
    for (int i = 0; i < got.size() && i < exp_moves.size(); i++) begin
      checks++;
      if (got[i] !== exp_moves[i]) begin errors++; $display("FAIL rr_move%0d: got %h want %h", i, got[i], exp_moves[i]); end
    end
    checks++; if (move_count !== CNTW'(exp_moves.size())) begin errors++; $display("FAIL rr_count: got %0d want %0d", move_count, exp_moves.size()); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    bit to = 1'b1;
    clear_bench();
    fifo_q[0].push_back(rand_word(50, 1));
    ready_mode = 0;
    tick(2);
    compute_expected();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    while (!move_valid && n < 20) begin
      tick(1);
      n++;
    end
    checks++; if (n != 3) begin errors++; $display("FAIL bp_latency: first valid after %0d cycles want 3", n); end
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checks++;
      if (move_valid !== 1'b1 || move_out !== exp_moves[0] || move_count !== '0) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b out=%h count=%0d want valid=1 out=%h count=0",
                 i, move_valid, move_out, move_count, exp_moves[0]);
      end
    end
    ready_mode = 1;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        to = 1'b0;
        break;
      end
      tick(1);
    end
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL bp_done_timeout: done=%b want 1", done); end
    checks++; if (got.size() != exp_moves.size()) begin errors++; $display("FAIL bp_nmoves: got %0d want %0d", got.size(), exp_moves.size()); end
    for (int i = 0; i < got.size() && i < exp_moves.size(); i++) begin
      checks++;
      if (got[i] !== exp_moves[i]) begin errors++; $display("FAIL bp_move%0d: got %h want %h", i, got[i], exp_moves[i]); end
    end
    checks++; if (move_count !== CNTW'(exp_moves.size())) begin errors++; $display("FAIL bp_count: got %0d want %0d", move_count, exp_moves.size()); end
  endtask

  task automatic test_col_done_late();
    int n = 0;
    clear_bench();
    col_done = 8'hBF;
    ready_mode = 1;
    tick(2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(40);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL late_wait: busy=%b done=%b want busy=1 done=0", busy, done); end
    col_done[6] = 1'b1;
    while (!done && n < NCOL + 1) begin
      tick(1);
      n++;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL late_done: done=%b after %0d cycles want 1", done, n); end
    checks++; if (move_count !== '0) begin errors++; $display("FAIL late_count: got %0d want 0", move_count); end
    col_done = '1;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    bit to;
    clear_bench();
    fifo_q[0].push_back(rand_word(100, 1));
    fifo_q[1].push_back(rand_word(100, 1));
    ready_mode = 0;
    tick(2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    while (!move_valid && n < 20) begin
      tick(1);
      n++;
    end
    reset = 1'b0;
    tick(1);
    checks++;
    if (col_rden !== '0 || move_valid !== 0 || move_count !== '0 || busy !== 0 || done !== 0) begin
      errors++;
      $display("FAIL midreset_state: rden=%h valid=%b count=%0d busy=%b done=%b want all 0",
               col_rden, move_valid, move_count, busy, done);
    end
    reset = 1'b1;
    clear_bench();
    for (int j = 0; j < 3; j++) fifo_q[$urandom_range(0, NCOL-1)].push_back(rand_word(70, 0));
    ready_mode = 2;
    tick(2);
    compute_expected();
    run_pass(600, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL midreset_timeout: done=%b want 1", done); end
    checks++; if (got.size() != exp_moves.size()) begin errors++; $display("FAIL midreset_nmoves: got %0d want %0d", got.size(), exp_moves.size()); end
    for (int i = 0; i < got.size() && i < exp_moves.size(); i++) begin
      checks++;
      if (got[i] !== exp_moves[i]) begin errors++; $display("FAIL midreset_move%0d: got %h want %h", i, got[i], exp_moves[i]); end
    end
    checks++; if (move_count !== CNTW'(exp_moves.size())) begin errors++; $display("FAIL midreset_count: got %0d want %0d", move_count, exp_moves.size()); end
  endtask

  task automatic test_saturate();
    logic [WORDW-1:0] w;
    bit to;
    clear_bench();
    for (int j = 0; j < 37; j++) fifo_q[$urandom_range(0, NCOL-1)].push_back(rand_word(100, 0));
    w = rand_word(100, 0);
    for (int k = 4; k < 8; k++) w[20*k + 18] = 1'b1;
    fifo_q[$urandom_range(0, NCOL-1)].push_back(w);
    ready_mode = 2;
    tick(2);
    compute_expected();
    run_pass(5000, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL sat_timeout: done=%b want 1", done); end
    checks++; if (got.size() != 300) begin errors++; $display("FAIL sat_nmoves: got %0d want 300", got.size()); end
    for (int i = 0; i < got.size() && i < exp_moves.size(); i++) begin
      checks++;
      if (got[i] !== exp_moves[i]) begin errors++; $display("FAIL sat_move%0d: got %h want %h", i, got[i], exp_moves[i]); end
    end
    checks++; if (move_count !== 8'd255) begin errors++; $display("FAIL sat_count: got %0d want 255", move_count); end
  endtask

  task automatic test_random();
    bit to;
    int want_cnt;
    for (int it = 0; it < 3; it++) begin
      clear_bench();
      for (int c = 0; c < NCOL; c++)
        repeat ($urandom_range(0, 2)) fifo_q[c].push_back(rand_word($urandom_range(0, 100), 0));
      ready_mode = 2;
      tick(2);
      compute_expected();
      run_pass(3000, to);
      want_cnt = (exp_moves.size() > 255) ? 255 : exp_moves.size();
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL rand%0d_timeout: done=%b want 1", it, done); end
      checks++; if (got.size() != exp_moves.size()) begin errors++; $display("FAIL rand%0d_nmoves: got %0d want %0d", it, got.size(), exp_moves.size()); end
      for (int i = 0; i < got.size() && i < exp_moves.size(); i++) begin
        checks++;
        if (got[i] !== exp_moves[i]) begin errors++; $display("FAIL rand%0d_move%0d: got %h want %h", it, i, got[i], exp_moves[i]); end
      end
      checks++; if (pop_log.size() != exp_pops.size()) begin errors++; $display("FAIL rand%0d_npops: got %0d want %0d", it, pop_log.size(), exp_pops.size()); end
      for (int i = 0; i < pop_log.size() && i < exp_pops.size(); i++) begin
        checks++;
        if (pop_log[i] != exp_pops[i]) begin errors++; $display("FAIL rand%0d_pop%0d: got col %0d want col %0d", it, i, pop_log[i], exp_pops[i]); end
      end
      checks++; if (move_count !== CNTW'(want_cnt)) begin errors++; $display("FAIL rand%0d_count: got %0d want %0d", it, move_count, want_cnt); end
    end
  endtask

  initial begin
    for (int c = 0; c < NCOL; c++) rden_cnt[c] = 0;
    test_reset();
    test_single_col();
    test_round_robin();
    test_backpressure();
    test_col_done_late();
    test_reset_mid();
    test_saturate();
    test_random();
    checks++;
    if (onehot_err != 0) begin errors++; $display("FAIL rden_onehot: %0d cycles with several read enables, want 0", onehot_err); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/board_move_collector.md
Name: board_move_collector

Overview:
- Board-level consumer of the eight column move FIFOs. It is the reader side of each column unit's fifoOut/fifoEmpty/rden interface.
- Scans the columns round-robin and pops 160-bit words from any non-empty column FIFO.
- Unpacks each word into 8 move slots, drops invalid slots, and streams legal 19-bit moves out over a valid/ready handshake.
- Counts the moves, and raises done once every column reports done and every column FIFO is drained.

Parameters:
- NCOL, 8, number of columns.
- WORDW, 160, column FIFO word width.
- SLOTW, 20, bits per slot inside a word.
- NSLOT, 8, slots per word (NSLOT*SLOTW = WORDW).
- CNTW, 8, move counter width.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-low.
- start  in  1  one-cycle pulse; begins a collection pass (honoured in IDLE and DONE only).
- col_done  in  NCOL  per-column done flags, bit i = column i.
- col_empty  in  NCOL  per-column FIFO empty flags.
- col_data  in  NCOL*WORDW  column FIFO q buses; column i occupies [WORDW*i +: WORDW].
- col_rden  out  NCOL  per-column FIFO read enables, registered, one-hot or zero.
- move_out  out  19  {7b flag, 6b from, 6b to}.
- move_valid  out  1  move_out is valid.
- move_ready  in  1  downstream accepts move_out.
- move_count  out  CNTW  moves accepted this pass; saturates at all-ones.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  pass complete; held until the next start or reset.

Behaviour:
- Reset (reset==0 at a posedge) puts the block in the following state:
  - state=IDLE, ptr=0, finished=0.
  - col_rden=0, move_valid=0, move_out=0, move_count=0, busy=0, done=0.
  - Reset applies mid-pass with no drain; any word already popped is discarded.
- Column FIFO read latency: col_data[i] is valid the cycle after col_rden[i] is high (non-showahead).
- Slot k = word[SLOTW*k +: 19]; bit SLOTW*k+19 is reserved and ignored.
- Flag bit 18 of a slot = invalid. Remaining flag bits, high to low: promote, pawn move, pawn 2 sq, en passant, castle, capture.
- States:
  - IDLE: on start -> SCAN; clear move_count, finished[] and done; ptr=0.
  - SCAN: examine column ptr, one column per cycle.
    - If ~col_empty[ptr]: register col_rden[ptr]=1 and go to READ.
    - Else if col_done[ptr]: set finished[ptr]; ptr=ptr+1 mod NCOL.
    - Else: ptr=ptr+1 mod NCOL.
    - If finished is all ones (including the bit set this cycle): go to DONE.
  - READ: col_rden high for exactly this cycle -> CAPT. col_rden=0 in every other state.
  - CAPT: latch col_data[ptr] into the word register; slot=0 -> EMIT.
  - EMIT: examine slot.
    - Invalid slot: skip in 1 cycle, move_valid stays 0.
    - Valid slot: move_valid=1, move_out=slot bits; hold both stable until move_ready.
    - On handshake (valid & ready): move_count++ (saturating), advance slot.
    - After slot NSLOT-1 is handled: ptr=ptr+1 mod NCOL -> SCAN. Exactly one word is popped per column visit, for fairness.
  - DONE: done=1, busy=0; start -> IDLE-equivalent clear and go to SCAN next cycle.
- finished[i] is only set when col_done[i] & col_empty[i] hold in the same cycle. A column that refills after being marked is not revisited; column units must not do this.
- col_done deasserting after finished[i] is set is ignored.
- start while busy: ignored.
- move_ready high while move_valid is low: no effect.
- Latency example: start in cycle 0 -> SCAN in cycle 1 -> col_rden[0] in cycle 2 -> CAPT in cycle 3 -> first move_valid in cycle 4 (column 0 non-empty, slot 0 valid).
- move_count saturates and does not wrap.

Decomposition:
- Package chess_move_pkg holds:
  - widths: MOVEW=19, SLOTW, NSLOT, WORDW;
  - flag bit indices (FLG_INVALID=18 ... FLG_CAPTURE=12), from/to field ranges;
  - a state encoding enum;
  - a function that extracts slot k from a word.
- One sub-module: col_rr_scan. It holds the round-robin ptr and finished[] register and outputs the "all finished" and "selected non-empty" decisions. The FSM and unpacking stay in the top module.

Test Plan:
- Only column 3 non-empty with one word (slots 0,2,5 valid: 0x0_0C1C, 0x0_0820, 0x0_1010; others flag bit 18 set), all col_done=1, move_ready=1 -> exactly 3 moves in slot order; move_count=3; done rises after the scan confirms all empty; col_rden[3] pulsed once.
- Columns 0 and 1 each hold 2 words -> pops alternate 0,1,0,1 (round-robin), never two consecutive pops from the same column.
- move_ready held low 5 cycles on the first valid move -> move_out and move_valid stable for all 5 cycles; move_count increments only on the handshake.
- col_done[6]=0 while all FIFOs are empty -> block stays busy and done=0; raising col_done[6] -> done within NCOL+1 cycles.
- reset asserted (low) during EMIT -> next cycle col_rden=0, move_valid=0, move_count=0, busy=0; start afterwards runs a clean pass.
- 300 valid moves -> move_count=255 (saturated), all 300 delivered.
